// File: rtl/asi_rw_arb.sv
// Read/write arbiter for the user-side memory port: one grant per burst, unused-grant
// timeout and per-direction burst counters. Optional macro ASI_ARB_RD_PRIO_EN selects fixed read priority.
module asi_rw_arb #(
    parameter int GNT_TMO = 15,
    parameter int CNT_W   = 16
) (
    input  logic             usr_clk,
    input  logic             usr_reset,
    input  logic             r_req,
    input  logic             r_busy,
    input  logic             r_last,
    input  logic             w_req,
    input  logic             w_busy,
    input  logic             w_last,
    output logic             rgranted,
    output logic             wgranted,
    output logic             tmo_err,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    // The timer never exceeds GNT_TMO-1, so clog2(GNT_TMO) bits always suffice.
    localparam int TW = (GNT_TMO < 2) ? 1 : $clog2(GNT_TMO);
    localparam logic [TW-1:0] TMO_LAST = TW'(GNT_TMO - 1);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_RD,
        ARB_WR
    } arb_state_t;

    arb_state_t       state_q, state_d;
    logic             last_srv_q, last_srv_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             started_q, started_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    logic pick_rd;
    logic pick_wr;
    logic own_busy;
    logic own_last;
    logic expired;

`ifdef ASI_ARB_RD_PRIO_EN
    assign pick_rd = r_req;
`else
    // last_srv_q==1 means write was served last, so read gets the tie.
    assign pick_rd = r_req && (!w_req || last_srv_q);
`endif
    assign pick_wr = w_req && !pick_rd;

    // Only the owning path's beats are observed; the other path is ignored.
    always_comb begin
        own_busy = 1'b0;
        own_last = 1'b0;
        case (state_q)
            ARB_RD: begin
                own_busy = r_busy;
                own_last = r_last;
            end
            ARB_WR: begin
                own_busy = w_busy;
                own_last = w_last;
            end
            default: begin
                own_busy = 1'b0;
                own_last = 1'b0;
            end
        endcase
    end

    assign expired = !started_q && (timer_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        last_srv_d = last_srv_q;
        timer_d    = timer_q;
        started_d  = started_q;
        tmo_d      = 1'b0;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;

        case (state_q)
            ARB_IDLE: begin
                timer_d   = '0;
                started_d = 1'b0;
                if (pick_rd) begin
                    state_d    = ARB_RD;
                    last_srv_d = 1'b0;
                end else if (pick_wr) begin
                    state_d    = ARB_WR;
                    last_srv_d = 1'b1;
                end
            end
            ARB_RD, ARB_WR: begin
                // A beat always beats expiry in the same cycle.
                if (own_busy && own_last) begin
                    state_d = ARB_IDLE;
                    if (state_q == ARB_RD) begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end else if (own_busy) begin
                    started_d = 1'b1;
                end else if (expired) begin
                    state_d = ARB_IDLE;
                    tmo_d   = 1'b1;
                end else if (!started_q) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            state_q    <= ARB_IDLE;
            last_srv_q <= 1'b1;
            timer_q    <= '0;
            started_q  <= 1'b0;
            tmo_q      <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_srv_q <= last_srv_d;
            timer_q    <= timer_d;
            started_q  <= started_d;
            tmo_q      <= tmo_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign rgranted = (state_q == ARB_RD);
    assign wgranted = (state_q == ARB_WR);
    assign tmo_err  = tmo_q;
    assign rd_cnt   = rd_cnt_q;
    assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_asi_rw_arb.sv
// Bench for asi_rw_arb: grant-order scoreboard plus per-scenario timing and counter checks.
// A second instance with CNT_W=4 shares all inputs to exercise counter wrap.
module tb_asi_rw_arb;

    localparam int TMO = 15;

    logic usr_clk = 1'b0;
    logic usr_reset = 1'b1;
    logic r_req = 1'b0, r_busy = 1'b0, r_last = 1'b0;
    logic w_req = 1'b0, w_busy = 1'b0, w_last = 1'b0;

    logic        rgranted, wgranted, tmo_err;
    logic [15:0] rd_cnt, wr_cnt;
    logic        rg4, wg4, tmo4;
    logic [3:0]  rd_cnt4, wr_cnt4;

    int  n_checks = 0;
    int  n_fail = 0;
    int  tmo_pulses = 0;
    int  cycle = 0;
    logic prev_rg = 1'b0, prev_wg = 1'b0;
    byte exp_q[$];

    always #5 usr_clk = ~usr_clk;

    asi_rw_arb #(.GNT_TMO(TMO), .CNT_W(16)) dut (
        .usr_clk(usr_clk), .usr_reset(usr_reset),
        .r_req(r_req), .r_busy(r_busy), .r_last(r_last),
        .w_req(w_req), .w_busy(w_busy), .w_last(w_last),
        .rgranted(rgranted), .wgranted(wgranted), .tmo_err(tmo_err),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    asi_rw_arb #(.GNT_TMO(TMO), .CNT_W(4)) dut4 (
        .usr_clk(usr_clk), .usr_reset(usr_reset),
        .r_req(r_req), .r_busy(r_busy), .r_last(r_last),
        .w_req(w_req), .w_busy(w_busy), .w_last(w_last),
        .rgranted(rg4), .wgranted(wg4), .tmo_err(tmo4),
        .rd_cnt(rd_cnt4), .wr_cnt(wr_cnt4)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge and
    // every new grant is popped against the expected-order queue.
    task automatic cyc;
        byte e;
        @(posedge usr_clk);
        #1;
        cycle++;
        if (rgranted && !prev_rg) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL grant_order: got R at cycle %0d, required no grant", cycle);
            end else begin
                e = exp_q.pop_front();
                $display("grant R at cycle %0d (expected %c)", cycle, e);
                if (e != "R") begin
                    n_fail++;
                    $display("FAIL grant_order: got R, required %c", e);
                end
            end
        end
        if (wgranted && !prev_wg) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL grant_order: got W at cycle %0d, required no grant", cycle);
            end else begin
                e = exp_q.pop_front();
                $display("grant W at cycle %0d (expected %c)", cycle, e);
                if (e != "W") begin
                    n_fail++;
                    $display("FAIL grant_order: got W, required %c", e);
                end
            end
        end
        n_checks++;
        if (rgranted && wgranted) begin
            n_fail++;
            $display("FAIL grant_excl: rgranted=1 wgranted=1, required at most one");
        end
        n_checks++;
        if (rg4 !== rgranted || wg4 !== wgranted || tmo4 !== tmo_err) begin
            n_fail++;
            $display("FAIL cnt4_track: r/w/tmo=%b%b%b, required %b%b%b", rg4, wg4, tmo4,
                     rgranted, wgranted, tmo_err);
        end
        if (tmo_err) tmo_pulses++;
        prev_rg = rgranted;
        prev_wg = wgranted;
    endtask

    task automatic test_reset;
        usr_reset = 1'b1;
        repeat (3) cyc();
        n_checks++;
        if ({rgranted, wgranted, tmo_err} !== 3'b000 || rd_cnt !== 16'd0 || wr_cnt !== 16'd0
            || rd_cnt4 !== 4'd0 || wr_cnt4 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: r/w/tmo=%b%b%b rd=%0d wr=%0d, required 000 0 0",
                     rgranted, wgranted, tmo_err, rd_cnt, wr_cnt);
        end
        usr_reset = 1'b0;
        cyc();
    endtask

    task automatic test_basic_read;
        int p0 = tmo_pulses;
        r_req = 1'b1;
        exp_q.push_back("R");
        cyc();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rgranted !== 1'b1) begin
                n_fail++;
                $display("FAIL rd_hold beat%0d: rgranted=%b, required 1", i, rgranted);
            end
            r_busy = 1'b1;
            r_last = (i == 3);
            if (i == 3) r_req = 1'b0;
            cyc();
        end
        r_busy = 1'b0;
        r_last = 1'b0;
        n_checks++;
        if (rgranted !== 1'b0 || rd_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL rd_done: rgranted=%b rd_cnt=%0d, required 0 1", rgranted, rd_cnt);
        end
        cyc();
        n_checks++;
        if (tmo_pulses != p0 || rgranted !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_no_tmo: pulses=%0d rgranted=%b, required %0d 0",
                     tmo_pulses, rgranted, p0);
        end
    endtask

    task automatic test_round_robin;
        int exp_rd, exp_wr;
        usr_reset = 1'b1;
        cyc();
        usr_reset = 1'b0;
`ifdef ASI_ARB_RD_PRIO_EN
        for (int i = 0; i < 4; i++) exp_q.push_back("R");
        exp_rd = 4;
        exp_wr = 0;
`else
        exp_q.push_back("R"); exp_q.push_back("W");
        exp_q.push_back("R"); exp_q.push_back("W");
        exp_rd = 2;
        exp_wr = 2;
`endif
        r_req = 1'b1;
        w_req = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ((rgranted | wgranted) !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_grant burst%0d: r=%b w=%b, required one high", i, rgranted, wgranted);
            end
            if (rgranted) begin
                r_busy = 1'b1;
                r_last = 1'b1;
            end else begin
                w_busy = 1'b1;
                w_last = 1'b1;
            end
            if (i == 3) begin
                r_req = 1'b0;
                w_req = 1'b0;
            end
            cyc();
            {r_busy, r_last, w_busy, w_last} = 4'b0000;
            n_checks++;
            if ((rgranted | wgranted) !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_dead burst%0d: r=%b w=%b, required 00", i, rgranted, wgranted);
            end
            cyc();
        end
        n_checks++;
        if (rd_cnt !== 16'(exp_rd) || wr_cnt !== 16'(exp_wr)) begin
            n_fail++;
            $display("FAIL rr_counts: rd=%0d wr=%0d, required %0d %0d", rd_cnt, wr_cnt, exp_rd, exp_wr);
        end
    endtask

    task automatic test_timeout;
        int p0 = tmo_pulses;
        logic [15:0] wr0 = wr_cnt;
        int n = 0;
        int guard = 0;
        w_req = 1'b1;
        exp_q.push_back("W");
        cyc();
        w_req = 1'b0;
        if (wgranted) n = 1;
        while (wgranted && guard < 40) begin
            cyc();
            guard++;
            if (wgranted) n++;
        end
        n_checks++;
        if (n != TMO) begin
            n_fail++;
            $display("FAIL tmo_len: granted %0d cycles, required %0d", n, TMO);
        end
        n_checks++;
        if (tmo_err !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_pulse: tmo_err=%b on grant drop, required 1", tmo_err);
        end
        cyc();
        n_checks++;
        if (tmo_err !== 1'b0 || tmo_pulses != p0 + 1 || wr_cnt !== wr0) begin
            n_fail++;
            $display("FAIL tmo_after: tmo_err=%b pulses=%0d wr_cnt=%0d, required 0 %0d %0d",
                     tmo_err, tmo_pulses, wr_cnt, p0 + 1, wr0);
        end
    endtask

    task automatic test_beat_on_expiry;
        int p0 = tmo_pulses;
        logic [15:0] rd0 = rd_cnt;
        r_req = 1'b1;
        exp_q.push_back("R");
        cyc();
        repeat (TMO - 1) cyc();
        n_checks++;
        if (rgranted !== 1'b1) begin
            n_fail++;
            $display("FAIL exp_cycle: rgranted=%b in granted cycle %0d, required 1", rgranted, TMO);
        end
        r_req = 1'b0;
        r_busy = 1'b1;
        cyc();
        r_busy = 1'b0;
        n_checks++;
        if (rgranted !== 1'b1 || tmo_err !== 1'b0) begin
            n_fail++;
            $display("FAIL exp_beat: rgranted=%b tmo_err=%b, required 1 0", rgranted, tmo_err);
        end
        repeat (20) cyc();
        n_checks++;
        if (rgranted !== 1'b1) begin
            n_fail++;
            $display("FAIL exp_frozen: rgranted=%b after idle gap, required 1", rgranted);
        end
        r_busy = 1'b1;
        r_last = 1'b1;
        cyc();
        r_busy = 1'b0;
        r_last = 1'b0;
        n_checks++;
        if (rgranted !== 1'b0 || rd_cnt !== rd0 + 16'd1 || tmo_pulses != p0) begin
            n_fail++;
            $display("FAIL exp_done: rgranted=%b rd_cnt=%0d pulses=%0d, required 0 %0d %0d",
                     rgranted, rd_cnt, tmo_pulses, rd0 + 16'd1, p0);
        end
        cyc();
    endtask

    task automatic test_counter_wrap;
        usr_reset = 1'b1;
        cyc();
        usr_reset = 1'b0;
        for (int i = 0; i < 17; i++) exp_q.push_back("R");
        r_req = 1'b1;
        cyc();
        for (int i = 0; i < 17; i++) begin
            r_busy = 1'b1;
            r_last = 1'b1;
            if (i == 16) r_req = 1'b0;
            cyc();
            r_busy = 1'b0;
            r_last = 1'b0;
            cyc();
        end
        n_checks++;
        if (rd_cnt4 !== 4'd1 || rd_cnt !== 16'd17 || wr_cnt4 !== 4'd0) begin
            n_fail++;
            $display("FAIL cnt_wrap: rd_cnt4=%0d rd_cnt=%0d wr_cnt4=%0d, required 1 17 0",
                     rd_cnt4, rd_cnt, wr_cnt4);
        end
    endtask

    task automatic test_reset_mid_burst;
        w_req = 1'b1;
        exp_q.push_back("W");
        cyc();
        w_busy = 1'b1;
        cyc();
        usr_reset = 1'b1;
        w_req = 1'b0;
        cyc();
        n_checks++;
        if ({rgranted, wgranted, tmo_err} !== 3'b000 || rd_cnt !== 16'd0 || wr_cnt !== 16'd0
            || rd_cnt4 !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_mid: r/w/tmo=%b%b%b rd=%0d wr=%0d, required 000 0 0",
                     rgranted, wgranted, tmo_err, rd_cnt, wr_cnt);
        end
        usr_reset = 1'b0;
        w_busy = 1'b0;
        cyc();
        w_req = 1'b1;
        exp_q.push_back("W");
        cyc();
        n_checks++;
        if (wgranted !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_regrant: wgranted=%b, required 1", wgranted);
        end
        w_busy = 1'b1;
        w_last = 1'b1;
        w_req = 1'b0;
        cyc();
        w_busy = 1'b0;
        w_last = 1'b0;
        n_checks++;
        if (wgranted !== 1'b0 || wr_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL rst_done: wgranted=%b wr_cnt=%0d, required 0 1", wgranted, wr_cnt);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_round_robin();
        test_timeout();
        test_beat_on_expiry();
        test_counter_wrap();
        test_reset_mid_burst();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL grant_missing: %0d expected grants not seen, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
